// File: rtl/regfile_mp_sb.sv
// Multi-read-port integer register file with optional write bypass and a
// per-register pending-write scoreboard; storage is zeroed by a post-reset sweep.
module regfile_mp_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 1 << ADDR_WIDTH,
    parameter int NUM_RD     = 2,
    parameter int BYPASS     = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic                         ready,
    input  logic                         we,
    input  logic [ADDR_WIDTH-1:0]        waddr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
    output logic [NUM_RD-1:0]            rbusy,
    input  logic                         issue_valid,
    input  logic [ADDR_WIDTH-1:0]        issue_rd,
    output logic [ADDR_WIDTH:0]          busy_count,
    input  logic [ADDR_WIDTH-1:0]        test_addr,
    output logic [DATA_WIDTH-1:0]        test_data
);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_idx_q, clr_idx_d;
    logic [NUM_REGS-1:0]     busy_q, busy_d;
    logic [DATA_WIDTH-1:0]   mem_q [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_CLEAR;
            clr_idx_q <= '0;
            busy_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        busy_d    = busy_q;
        case (state_q)
            S_CLEAR: begin
                if (clr_idx_q == LAST_IDX) state_d = S_RUN;
                else                       clr_idx_d = clr_idx_q + 1'b1;
            end
            S_RUN: begin
                // Issue is applied after writeback so a new producer wins on a tie.
                if (we) busy_d[waddr] = 1'b0;
                if (issue_valid && (issue_rd != '0)) busy_d[issue_rd] = 1'b1;
            end
            default: state_d = S_CLEAR;
        endcase
        busy_d[0] = 1'b0;
    end

    // Storage has no reset; the CLEAR sweep zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR)
            mem_q[clr_idx_q] <= '0;
        else if (we && (waddr != '0))
            mem_q[waddr] <= wdata;
    end

    assign ready = (state_q == S_RUN);

    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin : g_rd
            logic [ADDR_WIDTH-1:0] ra;
            logic                  hit;
            ra  = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            hit = (BYPASS != 0) && we && (waddr == ra);
            if (ready && (ra != '0)) begin
                rdata[i*DATA_WIDTH +: DATA_WIDTH] = hit ? wdata : mem_q[ra];
                rbusy[i]                          = busy_q[ra] && !hit;
            end
        end
    end

    always_comb begin
        test_data = '0;
        if (ready && (test_addr != '0)) test_data = mem_q[test_addr];
    end

    always_comb begin
        busy_count = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++)
            busy_count = busy_count + (ADDR_WIDTH+1)'(busy_q[r]);
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: one bypassing and one non-bypassing
// instance share stimulus; expected values are queued then popped at each check.
module tb_regfile_mp_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic             clk;
    logic             rst_n;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [DW-1:0]    wdata;
    logic [NR*AW-1:0] raddr;
    logic             issue_valid;
    logic [AW-1:0]    issue_rd;
    logic [AW-1:0]    test_addr;

    logic             ready,      nb_ready;
    logic [NR*DW-1:0] rdata,      nb_rdata;
    logic [NR-1:0]    rbusy,      nb_rbusy;
    logic [AW:0]      busy_count, nb_busy_count;
    logic [DW-1:0]    test_data,  nb_test_data;

    regfile_mp_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .ready(ready), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .issue_valid(issue_valid),
        .issue_rd(issue_rd), .busy_count(busy_count), .test_addr(test_addr),
        .test_data(test_data)
    );

    regfile_mp_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .BYPASS(0)) u_nb (
        .clk(clk), .rst_n(rst_n), .ready(nb_ready), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(nb_rdata), .rbusy(nb_rbusy), .issue_valid(issue_valid),
        .issue_rd(issue_rd), .busy_count(nb_busy_count), .test_addr(test_addr),
        .test_data(nb_test_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned  tests = 0;
    int unsigned  fails = 0;
    logic [63:0]  exp_q [$];

    task automatic expect_val(input logic [63:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs);
        logic [63:0] e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $error("FAIL %s: observed %0h but no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                fails++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
            end
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        raddr[p*AW +: AW] = a;
    endtask

    function automatic logic [DW-1:0] rd(input logic [NR*DW-1:0] bus, input int p);
        return bus[p*DW +: DW];
    endfunction

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick;
        we = 1'b0;
    endtask

    task automatic issue(input logic [AW-1:0] a);
        issue_valid = 1'b1; issue_rd = a;
        tick;
        issue_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
        issue_valid = 1'b0; issue_rd = '0; test_addr = '0;
        #1 rst_n = 1'b0;
        set_rd(0, 5'd5);
        #10;
        expect_val(0); chk("rst_ready", ready);
        expect_val(0); chk("rst_busy_count", busy_count);
        expect_val(0); chk("rst_rdata", rdata);

        // Clear sequence with a write and an issue attempted throughout
        @(negedge clk);
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD;
        issue_valid = 1'b1; issue_rd = 5'd6;
        for (int i = 0; i < 31; i++) begin
            tick;
            expect_val(0); chk("clr_ready_low", ready);
        end
        expect_val(0); chk("clr_rbusy", rbusy);
        expect_val(0); chk("clr_rdata0", rd(rdata, 0));
        tick;
        we = 1'b0; issue_valid = 1'b0;
        #1;
        expect_val(1); chk("ready_up", ready);
        expect_val(1); chk("nb_ready_up", nb_ready);
        expect_val(0); chk("clr_write_ignored_x5", rd(rdata, 0));
        expect_val(0); chk("clr_issue_ignored", busy_count);

        // Write/read and x0
        wr(5'd3, 32'h12345678);
        wr(5'd0, 32'hFFFFFFFF);
        set_rd(0, 5'd3); set_rd(1, 5'd0); test_addr = 5'd0;
        #1;
        expect_val(32'h12345678); chk("rd_x3", rd(rdata, 0));
        expect_val(0);            chk("rd_x0", rd(rdata, 1));
        expect_val(0);            chk("test_x0", test_data);
        set_rd(1, 5'd3); test_addr = 5'd3;
        #1;
        expect_val(32'h12345678); chk("same_reg_p0", rd(rdata, 0));
        expect_val(32'h12345678); chk("same_reg_p1", rd(rdata, 1));
        expect_val(32'h12345678); chk("test_x3", test_data);

        // Bypass vs. no bypass
        wr(5'd7, 32'h11111111);
        we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5;
        set_rd(1, 5'd7); test_addr = 5'd7;
        #1;
        expect_val(32'hA5A5A5A5); chk("bypass_rd1", rd(rdata, 1));
        expect_val(32'h11111111); chk("bypass_test_old", test_data);
        expect_val(32'h11111111); chk("nobypass_rd1", rd(nb_rdata, 1));
        tick;
        we = 1'b0;
        #1;
        expect_val(32'hA5A5A5A5); chk("after_wr_rd1", rd(rdata, 1));
        expect_val(32'hA5A5A5A5); chk("nb_after_wr_rd1", rd(nb_rdata, 1));

        // Scoreboard
        issue(5'd9);
        set_rd(0, 5'd9);
        #1;
        expect_val(1); chk("busy9_rbusy", rbusy[0]);
        expect_val(1); chk("busy_count_1", busy_count);
        issue(5'd10);
        expect_val(2); chk("busy_count_2", busy_count);
        we = 1'b1; waddr = 5'd9; wdata = 32'h99;
        #1;
        expect_val(0); chk("wb_fwd_rbusy", rbusy[0]);
        expect_val(1); chk("nb_wb_rbusy", nb_rbusy[0]);
        expect_val(2); chk("busy_count_pre_wb", busy_count);
        tick;
        we = 1'b0;
        #1;
        expect_val(1); chk("busy_count_post_wb", busy_count);
        expect_val(0); chk("busy9_cleared", rbusy[0]);

        // Issue + writeback same register, issue to x0, re-issue busy reg
        issue(5'd4);
        expect_val(2); chk("busy_count_x4", busy_count);
        issue_valid = 1'b1; issue_rd = 5'd4;
        we = 1'b1; waddr = 5'd4; wdata = 32'h44;
        tick;
        issue_valid = 1'b0; we = 1'b0;
        set_rd(0, 5'd4);
        #1;
        expect_val(1); chk("set_wins_rbusy", rbusy[0]);
        expect_val(2); chk("set_wins_count", busy_count);
        issue(5'd0);
        expect_val(2); chk("issue_x0_count", busy_count);
        issue(5'd10);
        expect_val(2); chk("reissue_busy_count", busy_count);

        // Asynchronous reset mid-operation
        issue(5'd11);
        expect_val(3); chk("busy_count_3", busy_count);
        wr(5'd2, 32'h55);
        set_rd(0, 5'd2);
        #1;
        expect_val(32'h55); chk("x2_written", rd(rdata, 0));
        #1 rst_n = 1'b0;
        #1;
        expect_val(0); chk("async_ready", ready);
        expect_val(0); chk("async_busy_count", busy_count);
        expect_val(0); chk("async_rdata", rdata);
        expect_val(0); chk("async_rbusy", rbusy);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40 && !ready; i++) tick;
        expect_val(1); chk("reclear_ready", ready);
        expect_val(0); chk("reclear_x2", rd(rdata, 0));
        expect_val(0); chk("reclear_busy_count", busy_count);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
